// File: rtl/zwait_arb.sv
// zwait_arb: Z80 wait-request arbiter, single clock domain (fclk).
//
// Collects single-cycle wait strobes from up to NSRC Z80-side sources and
// serves them one at a time in round-robin order. While a source is served
// the Z80 is held in WAIT (wait_n low) and the AVR is interrupted
// (spiint_n low). The service ends on the AVR's wait_end strobe or,
// optionally, on a timeout.
//
// Optional feature macro: ZWAIT_TIMEOUT_EN
//   defined   - timeout counter present; SERVE also ends after tmo_limit
//               cycles (tmo_limit = 0 disables it); tmo_flag records it.
//   undefined - no counter; tmo_limit/tmo_clr ignored; tmo_flag tied 0.
//
// Parameters:
//   NSRC  - number of wait sources (2..7)
//   TMO_W - width of the timeout counter and of tmo_limit
//
// Ports:
//   fclk      in   system clock
//   rst       in   synchronous reset, active-high
//   wait_req  in   [NSRC]  request strobes, bit i = source i
//   wait_mask in   [NSRC]  per-source enable, 1 = enabled
//   wait_end  in   acknowledge strobe from the SPI/AVR side
//   tmo_limit in   [TMO_W] timeout length in fclk cycles, 0 = disabled
//   tmo_clr   in   clears tmo_flag
//   waits     out  [7]     one-hot of the source in service, 0 when none
//   wait_src  out  [3]     id of the source in service (holds last value)
//   pending   out  [NSRC]  latched requests not yet served
//   wait_n    out  Z80 WAIT, active-low
//   spiint_n  out  AVR interrupt, active-low
//   tmo_flag  out  sticky flag, set when a service ended by timeout

module zwait_arb #(
  parameter int NSRC  = 7,
  parameter int TMO_W = 16
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic [NSRC-1:0]  wait_req,
  input  logic [NSRC-1:0]  wait_mask,
  input  logic             wait_end,
  input  logic [TMO_W-1:0] tmo_limit,
  input  logic             tmo_clr,
  output logic [6:0]       waits,
  output logic [2:0]       wait_src,
  output logic [NSRC-1:0]  pending,
  output logic             wait_n,
  output logic             spiint_n,
  output logic             tmo_flag
);

  typedef enum logic [1:0] {IDLE, SERVE, RELEASE} state_t;

  state_t          state, state_d;
  logic [2:0]      last_src, last_src_d;
  logic [6:0]      waits_d;
  logic [2:0]      wait_src_d;
  logic [NSRC-1:0] pending_d;
  logic [NSRC-1:0] clr;
  logic            wait_n_d, spiint_n_d;
  logic            tmo_hit;
  logic [2:0]      grant, grant_hi, grant_lo;
  logic            found_hi;

  // Round-robin pick: the lowest pending source above last_src wins;
  // if there is none, wrap around to the lowest pending source overall.
  // Scanning downward lets the last assignment be the lowest index.
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    found_hi = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_lo = 3'(i);
        if (i > int'(last_src)) begin
          grant_hi = 3'(i);
          found_hi = 1'b1;
        end
      end
    end
    grant = found_hi ? grant_hi : grant_lo;
  end

`ifdef ZWAIT_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  // The counter sits at zero outside SERVE, so it is zero on the first
  // SERVE cycle; reaching limit-1 means this is the limit-th SERVE cycle.
  assign tmo_hit = (state == SERVE) && (tmo_limit != '0) &&
                   (tmo_cnt == tmo_limit - TMO_W'(1));

  // Timeout counter and sticky flag; a timeout that coincides with
  // wait_end is treated as a normal end, and a set beats a clear.
  always_ff @(posedge fclk) begin
    if (rst) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (state == SERVE) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else                tmo_cnt <= '0;
      if (tmo_hit && !wait_end) tmo_flag <= 1'b1;
      else if (tmo_clr)         tmo_flag <= 1'b0;
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign tmo_flag   = 1'b0;
  assign unused_tmo = ^{tmo_limit, tmo_clr};
`endif

  // Next-state and next-output logic. Outputs are computed one cycle
  // ahead so that every output comes straight from a flop.
  always_comb begin
    state_d    = state;
    waits_d    = waits;
    wait_src_d = wait_src;
    last_src_d = last_src;
    wait_n_d   = wait_n;
    spiint_n_d = spiint_n;
    clr        = '0;
    case (state)
      IDLE: begin
        if (|pending) begin
          state_d    = SERVE;
          waits_d    = 7'b1 << grant;
          wait_src_d = grant;
          last_src_d = grant;
          wait_n_d   = 1'b0;
          spiint_n_d = 1'b0;
        end
      end
      SERVE: begin
        if (wait_end || tmo_hit) begin
          state_d    = RELEASE;
          clr        = waits[NSRC-1:0];
          waits_d    = '0;
          wait_n_d   = 1'b1;
          spiint_n_d = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The served source's bit is dropped only as SERVE ends, so a repeat
    // strobe from it during SERVE is absorbed rather than queued again.
    pending_d = (pending | (wait_req & wait_mask)) & wait_mask & ~clr;
  end

  // State and output registers.
  always_ff @(posedge fclk) begin
    if (rst) begin
      state    <= IDLE;
      waits    <= '0;
      wait_src <= '0;
      last_src <= 3'(NSRC - 1);
      pending  <= '0;
      wait_n   <= 1'b1;
      spiint_n <= 1'b1;
    end else begin
      state    <= state_d;
      waits    <= waits_d;
      wait_src <= wait_src_d;
      last_src <= last_src_d;
      pending  <= pending_d;
      wait_n   <= wait_n_d;
      spiint_n <= spiint_n_d;
    end
  end

endmodule

// File: doc/zwait_arb.md
# zwait_arb

Synchronous wait-request arbiter for the Z80 bus, clocked on `fclk`. It collects wait strobes from up to seven Z80-side sources (gluclock, comport, future extensions) and grants them one at a time, round-robin. For each grant it holds the Z80 in WAIT and signals the AVR through `spiint_n`, then releases on the AVR's `wait_end` strobe or, optionally, on a timeout.

## Interface
Parameters:
- `NSRC`, 7: number of wait sources, 2..7; `waits` bits at index `NSRC` and above read 0.
- `TMO_W`, 16: width of the timeout counter and of `tmo_limit`.

Ports:
- `fclk`  in  1: system clock; the only clock.
- `rst`  in  1: synchronous reset, active-high.
- `wait_req`  in  NSRC: single-cycle request strobes, already synchronous to `fclk`; bit i is source i.
- `wait_mask`  in  NSRC: per-source enable from the config register; 1 = enabled.
- `wait_end`  in  1: single-cycle acknowledge strobe from the SPI/AVR side.
- `tmo_limit`  in  TMO_W: timeout length in `fclk` cycles; 0 = timeout disabled.
- `tmo_clr`  in  1: clears `tmo_flag`.
- `waits`  out  7: one-hot of the source in service; 0 when none.
- `wait_src`  out  3: encoded id of the source in service; holds its last value otherwise.
- `pending`  out  NSRC: latched, not-yet-served requests.
- `wait_n`  out  1: Z80 WAIT, active-low, push-pull; the top level converts it to open-drain.
- `spiint_n`  out  1: AVR interrupt, active-low.
- `tmo_flag`  out  1: sticky flag, set when a service was ended by timeout.

## Operation
- All outputs are registered.
- Reset values: `waits`=0, `wait_src`=0, `pending`=0, `wait_n`=1, `spiint_n`=1, `tmo_flag`=0, state IDLE. Internal `last_src`=NSRC-1, so the first search starts at source 0.
- Pending update, every cycle: `pending` <= (`pending` | (`wait_req` & `wait_mask`)) & `wait_mask` & ~clr.
  - clr is the one-hot of the serviced source on the SERVE→RELEASE edge.
  - A request for the source currently in SERVE is merged, not re-latched.
- Clearing a mask bit drops that source's pending bit. A source already in SERVE continues until `wait_end` or timeout.
- FSM states:
  - IDLE: if `pending` ≠ 0, grant the first set bit searching upward from (`last_src`+1) mod NSRC with wrap-around. Load `waits` one-hot, `wait_src`, `last_src`. Go to SERVE.
  - SERVE: `wait_n`=0, `spiint_n`=0. On `wait_end`, or on timeout, go to RELEASE.
  - RELEASE: `waits`=0, `wait_n`=1, `spiint_n`=1 for exactly one cycle, then go to IDLE.
- `wait_end` is ignored in IDLE and RELEASE.
- `wait_end` and timeout in the same cycle count as `wait_end`: `tmo_flag` is not set.
- `tmo_flag`:
  - set on a timeout-ended SERVE; otherwise holds until `tmo_clr`.
  - If set and clear occur in the same cycle, set wins.
- A `wait_req` in RELEASE for the just-served source sets its pending bit again; the source is re-granted by round-robin order.

## Timing
- Request strobe sampled at edge k → `pending[i]`=1 after edge k → grant at edge k+1 → `wait_n` low after edge k+1. This is 2 cycles from strobe to WAIT when the FSM is idle.
- `wait_end` sampled at edge m → `wait_n`, `spiint_n` high and `waits`=0 after edge m.
- After edge m+1 the FSM is in IDLE. The earliest next grant is at edge m+2, so `wait_n` stays high for at least 2 cycles between services.
- Timeout: counter cleared on entry to SERVE and incremented each SERVE cycle. When the counter reaches `tmo_limit`-1 without `wait_end`, the FSM leaves SERVE on that edge. SERVE therefore lasts exactly `tmo_limit` cycles.
- `rst` mid-service: `wait_n` is high after the reset edge and all pending requests are discarded.

## Configuration
- `ZWAIT_TIMEOUT_EN` defined: timeout counter present; behaviour as above.
- `ZWAIT_TIMEOUT_EN` undefined:
  - no counter;
  - `tmo_limit` and `tmo_clr` ignored;
  - `tmo_flag` tied 0;
  - SERVE ends only on `wait_end`.

## Test plan
- Reset: hold `rst`=1 for 3 cycles → `wait_n`=1, `spiint_n`=1, `waits`=0, `pending`=0, `wait_src`=0.
- `wait_req`=0000001 strobe at edge k, mask all 1 → `wait_n`=0 and `waits`=0000001 after edge k+1. `wait_end` at edge k+5 → `wait_n`=1 after k+5, FSM in IDLE after k+6.
- Simultaneous strobes `wait_req`=0000011 → source 0 served, then `pending`=0000010. After `wait_end`, source 1 is granted exactly 2 cycles later with `wait_src`=1.
- Fairness: source 0 re-requests during every RELEASE while source 1 stays pending → grants alternate 0,1,0,1.
- Mask: pending=0000100, clear `wait_mask[2]` → `pending`=0 next cycle, no grant. Clearing the mask bit of the in-service source does not release WAIT.
- With `ZWAIT_TIMEOUT_EN`, `tmo_limit`=8, no `wait_end` → `wait_n` low for exactly 8 cycles, then `tmo_flag`=1 until `tmo_clr`. With `tmo_limit`=0 → WAIT held indefinitely.
